// File: rtl/system_datapath_pkg.sv
// Shared definitions for the single-bus datapath: ALU opcodes, IR field
// positions, branch condition codes and the GPR select helper.
package system_datapath_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_NEG  = 5'b01110,
    OP_NOT  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_DIV  = 5'b10001
  } alu_op_e;

  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_LSB = 15;
  localparam int unsigned IR_C2_LSB = 19;
  localparam int unsigned IR_C_MSB  = 18;

  typedef enum logic [1:0] {
    C2_ZERO    = 2'b00,
    C2_NONZERO = 2'b01,
    C2_POS     = 2'b10,
    C2_NEG     = 2'b11
  } c2_cond_e;

  // Simultaneous G-selects merge their register numbers bitwise.
  function automatic logic [2:0] sel_gpr(input logic [31:0] ir,
                                         input logic gra, input logic grb,
                                         input logic grc);
    return ({3{gra}} & ir[IR_RA_LSB +: 3]) |
           ({3{grb}} & ir[IR_RB_LSB +: 3]) |
           ({3{grc}} & ir[IR_RC_LSB +: 3]);
  endfunction

endpackage

// File: rtl/system_datapath_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit result for Zhi:Zlo.
// Multiply/divide exist only when SYSTEM_MULDIV_EN is defined.
module system_alu
  import system_datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  opcode,
  input  logic        inc_pc,
  output logic [63:0] z
);

  logic [4:0]  sh;
  logic [63:0] dbl_r;
  logic [63:0] dbl_l;
`ifdef SYSTEM_MULDIV_EN
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
`endif

  always_comb begin
    z     = '0;
    sh    = b[4:0];
    // Rotates come from shifting a doubled copy of A.
    dbl_r = {a, a} >> sh;
    dbl_l = {a, a} << sh;
`ifdef SYSTEM_MULDIV_EN
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    sa    = a;
    sb    = b;
`endif
    if (inc_pc) begin
      z = {32'd0, b + 32'd1};
    end else begin
      case (opcode)
        OP_ADD:  z = {32'd0, a + b};
        OP_SUB:  z = {32'd0, a - b};
        OP_AND:  z = {32'd0, a & b};
        OP_OR:   z = {32'd0, a | b};
        OP_SHR:  z = {32'd0, a >> sh};
        OP_SHRA: z = {32'd0, 32'($signed(a) >>> sh)};
        OP_SHL:  z = {32'd0, a << sh};
        OP_ROR:  z = {32'd0, dbl_r[31:0]};
        OP_ROL:  z = {32'd0, dbl_l[63:32]};
        OP_NEG:  z = {32'd0, 32'd0 - b};
        OP_NOT:  z = {32'd0, ~b};
`ifdef SYSTEM_MULDIV_EN
        OP_MUL:  z = a_ext * b_ext;
        OP_DIV:  if (b != 32'd0) z = {32'(sa % sb), 32'(sa / sb)};
`endif
        default: z = '0;
      endcase
    end
  end

endmodule

// File: rtl/system_datapath.sv
// Single-bus 32-bit CPU datapath with register file, staging registers,
// I/O ports, branch flip-flop and a 512x32 memory. Optional: SYSTEM_MULDIV_EN.
module system_datapath
  import system_datapath_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                        Clock,
  input  logic                        clear,
  input  logic [DATA_WIDTH-1:0]       inport_data,
  input  logic                        inport_data_ready,
  input  logic                        outport_in,
  output logic [DATA_WIDTH-1:0]       outport_data,
  input  logic                        HIout,
  input  logic                        LOout,
  input  logic                        Zhi_out,
  input  logic                        Zlo_out,
  input  logic                        PCout,
  input  logic                        MDRout,
  input  logic                        Inport_out,
  input  logic                        Cout,
  input  logic                        MARin,
  input  logic                        Zin,
  input  logic                        PCin,
  input  logic                        MDRin,
  input  logic                        IRin,
  input  logic                        Yin,
  input  logic                        HIin,
  input  logic                        LOin,
  input  logic                        Gra,
  input  logic                        Grb,
  input  logic                        Grc,
  input  logic                        Rin,
  input  logic                        Rout,
  input  logic                        BAout,
  input  logic [4:0]                  opcode,
  input  logic                        IncPC,
  input  logic                        Mem_Read,
  input  logic                        Mem_Write,
  input  logic                        Mem_enable512x32,
  output logic                        con_ff_bit,
  output logic [7:0][DATA_WIDTH-1:0]  register,
  output logic [DATA_WIDTH-1:0]       registerMDR,
  output logic [DATA_WIDTH-1:0]       registerPC,
  output logic [DATA_WIDTH-1:0]       registerHI,
  output logic [DATA_WIDTH-1:0]       registerLO,
  output logic [DATA_WIDTH-1:0]       registerIR,
  output logic [DATA_WIDTH-1:0]       BusMuxOut,
  output logic [DATA_WIDTH-1:0]       Mem_to_datapath,
  output logic [DATA_WIDTH-1:0]       Mem_data_to_chip,
  output logic [DATA_WIDTH-1:0]       MAR_address
);

  logic [7:0][DATA_WIDTH-1:0] gpr_q, gpr_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d, pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] inport_q, inport_d, outport_q, outport_d;
  logic [2*DATA_WIDTH-1:0] z_q, z_d, alu_z;
  logic con_ff_q, con_ff_d;

  logic [2:0]            gpr_idx;
  logic [DATA_WIDTH-1:0] bus;
  logic [DATA_WIDTH-1:0] c_sext;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  cond_met;
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  assign gpr_idx = sel_gpr(ir_q, Gra, Grb, Grc);
  assign c_sext  = {{(DATA_WIDTH-IR_C_MSB-1){ir_q[IR_C_MSB]}}, ir_q[IR_C_MSB:0]};

  always_comb begin
    bus = '0;
    if (Rout || BAout) begin
      bus = (BAout && gpr_idx == 3'd0) ? '0 : gpr_q[gpr_idx];
    end else if (HIout)      bus = hi_q;
    else if (LOout)          bus = lo_q;
    else if (Zhi_out)        bus = z_q[2*DATA_WIDTH-1:DATA_WIDTH];
    else if (Zlo_out)        bus = z_q[DATA_WIDTH-1:0];
    else if (PCout)          bus = pc_q;
    else if (MDRout)         bus = mdr_q;
    else if (Inport_out)     bus = inport_q;
    else if (Cout)           bus = c_sext;
  end

  assign mem_rdata = (Mem_enable512x32 && Mem_Read) ? mem[mar_q[ADDR_WIDTH-1:0]] : '0;

  always_comb begin
    cond_met = 1'b0;
    case (c2_cond_e'(ir_q[IR_C2_LSB +: 2]))
      C2_ZERO:    cond_met = (bus == '0);
      C2_NONZERO: cond_met = (bus != '0);
      C2_POS:     cond_met = ~bus[DATA_WIDTH-1];
      C2_NEG:     cond_met = bus[DATA_WIDTH-1];
      default:    cond_met = 1'b0;
    endcase
  end

  system_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .opcode (opcode),
    .inc_pc (IncPC),
    .z      (alu_z)
  );

  always_comb begin
    gpr_d     = gpr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    y_d       = y_q;
    z_d       = z_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    inport_d  = inport_q;
    outport_d = outport_q;
    con_ff_d  = con_ff_q;
    if (Rin)               gpr_d[gpr_idx] = bus;
    if (HIin)              hi_d      = bus;
    if (LOin)              lo_d      = bus;
    if (Yin)               y_d       = bus;
    if (Zin)               z_d       = alu_z;
    if (PCin)              pc_d      = bus;
    if (IRin)              ir_d      = bus;
    if (MARin)             mar_d     = bus;
    if (MDRin)             mdr_d     = Mem_Read ? mem_rdata : bus;
    if (inport_data_ready) inport_d  = inport_data;
    if (outport_in)        outport_d = bus;
    if (Gra && Rout)       con_ff_d  = cond_met;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      gpr_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_ff_q  <= 1'b0;
    end else begin
      gpr_q     <= gpr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      y_q       <= y_d;
      z_q       <= z_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      inport_q  <= inport_d;
      outport_q <= outport_d;
      con_ff_q  <= con_ff_d;
    end
  end

  // Memory contents survive clear; it writes the MDR value held before the edge.
  always_ff @(posedge Clock) begin
    if (Mem_enable512x32 && Mem_Write) mem[mar_q[ADDR_WIDTH-1:0]] <= mdr_q;
  end

  assign outport_data     = outport_q;
  assign con_ff_bit       = con_ff_q;
  assign register         = gpr_q;
  assign registerMDR      = mdr_q;
  assign registerPC       = pc_q;
  assign registerHI       = hi_q;
  assign registerLO       = lo_q;
  assign registerIR       = ir_q;
  assign BusMuxOut        = bus;
  assign Mem_to_datapath  = mem_rdata;
  assign Mem_data_to_chip = mdr_q;
  assign MAR_address      = mar_q;

endmodule

// File: tb/tb_system_datapath.sv
// Self-checking bench for system_datapath: directed micro-step sequences,
// an ALU vector table and randomized ALU operations against a reference model.
module tb_system_datapath;

  logic Clock = 1'b0;
  logic clear = 1'b1;
  logic [31:0] inport_data;
  logic inport_data_ready, outport_in;
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] opcode;
  logic IncPC, Mem_Read, Mem_Write, Mem_enable512x32;
  logic [31:0] outport_data;
  logic con_ff_bit;
  logic [7:0][31:0] register;
  logic [31:0] registerMDR, registerPC, registerHI, registerLO, registerIR, BusMuxOut;
  logic [31:0] Mem_to_datapath, Mem_data_to_chip, MAR_address;

  int n_pass  = 0;
  int n_total = 0;

  system_datapath #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
    .Clock(Clock), .clear(clear),
    .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_in(outport_in), .outport_data(outport_data),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .opcode(opcode), .IncPC(IncPC),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .con_ff_bit(con_ff_bit), .register(register),
    .registerMDR(registerMDR), .registerPC(registerPC), .registerHI(registerHI),
    .registerLO(registerLO), .registerIR(registerIR), .BusMuxOut(BusMuxOut),
    .Mem_to_datapath(Mem_to_datapath), .Mem_data_to_chip(Mem_data_to_chip),
    .MAR_address(MAR_address)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } alu_vec_t;

  alu_vec_t vecs[$];
  logic [4:0] ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                           5'd11, 5'd14, 5'd15, 5'd16, 5'd17};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    {inport_data_ready, outport_in, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout} = '0;
    {Inport_out, Cout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Mem_Read, Mem_Write, Mem_enable512x32} = '0;
    opcode = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_inport(input logic [31:0] v);
    inport_data = v; inport_data_ready = 1'b1; step(); inport_data_ready = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    set_inport(v); Inport_out = 1'b1; IRin = 1'b1; step(); idle();
  endtask

  task automatic load_gpr(input int unsigned idx, input logic [31:0] v);
    logic [31:0] irv;
    irv = '0;
    irv[26:23] = 4'(idx);
    load_ir(irv);
    set_inport(v); Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; step(); idle();
  endtask

  // Y <= R2, Z <= Y op R3, R1 <= Zlo; Zhi observed on the bus.
  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi);
    load_gpr(2, a);
    load_gpr(3, b);
    load_ir(32'h0091_8000);
    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; step(); idle();
    Grc = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1; step(); idle();
    Zhi_out = 1'b1; #1; hi = BusMuxOut; Zhi_out = 1'b0;
    Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; step(); idle();
    lo = register[1];
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, pw;
    longint sa, q;
    int unsigned n;
    logic [31:0] r;
    ua = a; ub = b; n = b % 32; pw = 64'd1 << n; r = a;
    sa = $signed(a);
    case (op)
      5'd3:  return {32'd0, 32'(ua + ub)};
      5'd4:  return {32'd0, 32'(ua + 64'h1_0000_0000 - ub)};
      5'd5:  return {32'd0, a & b};
      5'd6:  return {32'd0, a | b};
      5'd7:  return {32'd0, 32'(ua / pw)};
      5'd8: begin
        q = sa / longint'(pw);
        if (sa < 0 && (sa % longint'(pw)) != 0) q = q - 1;
        return {32'd0, 32'(q)};
      end
      5'd9:  return {32'd0, 32'(ua * pw)};
      5'd10: begin
        for (int unsigned i = 0; i < n; i++) r = {r[0], r[31:1]};
        return {32'd0, r};
      end
      5'd11: begin
        for (int unsigned i = 0; i < n; i++) r = {r[30:0], r[31]};
        return {32'd0, r};
      end
      5'd14: return {32'd0, 32'(64'h1_0000_0000 - ub)};
      5'd15: return {32'd0, 32'hFFFF_FFFF - b};
`ifdef SYSTEM_MULDIV_EN
      5'd16: return 64'(sa * longint'($signed(b)));
      5'd17: begin
        if (b == 32'd0) return 64'd0;
        return {32'(sa % longint'($signed(b))), 32'(sa / longint'($signed(b)))};
      end
`endif
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] lo, hi;
    logic [63:0] exp;
    logic [4:0]  op;
    logic [31:0] a, b;

    idle();
    inport_data = '0;
    #3 clear = 1'b0;
    step(); step();
    check("rst_pc", registerPC, 32'h0);
    check("rst_outport", outport_data, 32'h0);
    check("rst_conff", {31'b0, con_ff_bit}, 32'h0);
    check("rst_bus_idle", BusMuxOut, 32'h0);
    clear = 1'b1;
    step();

    // mem[0] = fetch word, mem[5] = 0x77
    set_inport(32'h0); Inport_out = 1'b1; MARin = 1'b1; step(); idle();
    set_inport(32'h2891_8000); Inport_out = 1'b1; MDRin = 1'b1; step(); idle();
    Mem_enable512x32 = 1'b1; Mem_Write = 1'b1; step(); idle();
    set_inport(32'h5); Inport_out = 1'b1; MARin = 1'b1; step(); idle();
    set_inport(32'h77); Inport_out = 1'b1; MDRin = 1'b1; step(); idle();
    check("mem_data_to_chip", Mem_data_to_chip, 32'h77);
    Mem_enable512x32 = 1'b1; Mem_Write = 1'b1; step(); idle();
    Mem_enable512x32 = 1'b1; Mem_Read = 1'b1; #1;
    check("mem5_readback", Mem_to_datapath, 32'h77);
    Mem_enable512x32 = 1'b0; #1;
    check("mem_read_disabled", Mem_to_datapath, 32'h0);
    idle();

    // Fetch
    PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1; step(); idle();
    check("t0_mar", MAR_address, 32'h0);
    Zlo_out = 1'b1; PCin = 1'b1; Mem_enable512x32 = 1'b1; Mem_Read = 1'b1; MDRin = 1'b1; #1;
    check("t1_zlo_bus", BusMuxOut, 32'h1);
    check("t1_mem_data", Mem_to_datapath, 32'h2891_8000);
    step(); idle();
    check("t1_pc", registerPC, 32'h1);
    check("t1_mdr", registerMDR, 32'h2891_8000);
    MDRout = 1'b1; IRin = 1'b1; step(); idle();
    check("t2_ir", registerIR, 32'h2891_8000);

    // I/O
    set_inport(32'hA5); Inport_out = 1'b1; outport_in = 1'b1; step(); idle();
    check("outport", outport_data, 32'hA5);

    // Bus sources and priority
    set_inport(32'h1111); Inport_out = 1'b1; HIin = 1'b1; step(); idle();
    set_inport(32'h2222); Inport_out = 1'b1; LOin = 1'b1; step(); idle();
    check("hi_reg", registerHI, 32'h1111);
    check("lo_reg", registerLO, 32'h2222);
    HIout = 1'b1; LOout = 1'b1; #1;
    check("bus_hi_over_lo", BusMuxOut, 32'h1111);
    HIout = 1'b0; #1;
    check("bus_lo", BusMuxOut, 32'h2222);
    idle();
    load_gpr(0, 32'h55);
    check("r0_written", register[0], 32'h55);
    load_ir(32'h0);
    Gra = 1'b1; BAout = 1'b1; #1;
    check("baout_r0", BusMuxOut, 32'h0);
    BAout = 1'b0; Rout = 1'b1; HIout = 1'b1; #1;
    check("rout_r0_over_hi", BusMuxOut, 32'h55);
    idle();
    load_gpr(5, 32'h99);
    Gra = 1'b1; BAout = 1'b1; #1;
    check("baout_r5", BusMuxOut, 32'h99);
    idle();
    load_gpr(3, 32'h3333);
    load_ir(32'h0091_8000);
    Gra = 1'b1; Grb = 1'b1; Rout = 1'b1; #1;
    check("gsel_or_r3", BusMuxOut, 32'h3333);
    idle();
    load_ir(32'h0004_0001);
    Cout = 1'b1; #1;
    check("c_sext_neg", BusMuxOut, 32'hFFFC_0001);
    idle();
    load_ir(32'h0003_FFFF);
    Cout = 1'b1; #1;
    check("c_sext_pos", BusMuxOut, 32'h0003_FFFF);
    idle();

    // Branch condition
    load_gpr(4, 32'h0);
    load_ir(32'h0200_0000);
    Gra = 1'b1; Rout = 1'b1; step(); idle();
    check("conff_eq0", {31'b0, con_ff_bit}, 32'h1);
    load_ir(32'h0208_0000);
    Gra = 1'b1; Rout = 1'b1; step(); idle();
    check("conff_ne0_false", {31'b0, con_ff_bit}, 32'h0);
    load_gpr(4, 32'h8000_0000);
    load_ir(32'h0218_0000);
    Gra = 1'b1; Rout = 1'b1; step(); idle();
    check("conff_neg", {31'b0, con_ff_bit}, 32'h1);
    load_ir(32'h0210_0000);
    Gra = 1'b1; Rout = 1'b1; step(); idle();
    check("conff_pos_false", {31'b0, con_ff_bit}, 32'h0);

    // ALU vector table
    vecs.push_back('{5'd3,  32'h12,        32'h14,        32'h26,        32'h0, "add"});
    vecs.push_back('{5'd4,  32'h12,        32'h14,        32'hFFFF_FFFE, 32'h0, "sub"});
    vecs.push_back('{5'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, "and"});
    vecs.push_back('{5'd6,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0, "or"});
    vecs.push_back('{5'd7,  32'h8000_0000, 32'h4,         32'h0800_0000, 32'h0, "shr"});
    vecs.push_back('{5'd8,  32'h8000_0000, 32'h4,         32'hF800_0000, 32'h0, "shra"});
    vecs.push_back('{5'd9,  32'h1,         32'h1F,        32'h8000_0000, 32'h0, "shl31"});
    vecs.push_back('{5'd9,  32'h1,         32'h21,        32'h2,         32'h0, "shl_amt5"});
    vecs.push_back('{5'd10, 32'h1,         32'h1,         32'h8000_0000, 32'h0, "ror"});
    vecs.push_back('{5'd11, 32'h8000_0000, 32'h1,         32'h1,         32'h0, "rol"});
    vecs.push_back('{5'd14, 32'h1234,      32'h1,         32'hFFFF_FFFF, 32'h0, "neg"});
    vecs.push_back('{5'd15, 32'h1234,      32'h0000_FFFF, 32'hFFFF_0000, 32'h0, "not"});
    vecs.push_back('{5'd0,  32'h5,         32'h6,         32'h0,         32'h0, "undef_op"});
`ifdef SYSTEM_MULDIV_EN
    vecs.push_back('{5'd16, 32'h3,         32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFFF, "mul"});
    vecs.push_back('{5'd17, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, "div"});
    vecs.push_back('{5'd17, 32'h7,         32'h0,         32'h0,         32'h0, "div0"});
`else
    vecs.push_back('{5'd16, 32'h3,         32'hFFFF_FFFE, 32'h0,         32'h0, "mul_off"});
    vecs.push_back('{5'd17, 32'h7,         32'hFFFF_FFFE, 32'h0,         32'h0, "div_off"});
`endif
    foreach (vecs[i]) begin
      run_alu(vecs[i].op, vecs[i].a, vecs[i].b, lo, hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
    end

    // Randomized ALU operations against the reference model
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 12)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp = ref_alu(op, a, b);
      run_alu(op, a, b, lo, hi);
      check($sformatf("rand%0d_op%0d_lo", k, op), lo, exp[31:0]);
      check($sformatf("rand%0d_op%0d_hi", k, op), hi, exp[63:32]);
    end

    // Asynchronous clear with every register nonzero
    run_alu(5'd3, 32'h1234, 32'h1, lo, hi);
    load_gpr(7, 32'hDEAD_BEEF);
    set_inport(32'h5); Inport_out = 1'b1; MARin = 1'b1; HIin = 1'b1; PCin = 1'b1; step(); idle();
    Grb = 1'b1; Rout = 1'b1; Gra = 1'b1; step(); idle();
    #2 clear = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("clr_r%0d", i), register[i], 32'h0);
    check("clr_hi", registerHI, 32'h0);
    check("clr_lo", registerLO, 32'h0);
    check("clr_pc", registerPC, 32'h0);
    check("clr_ir", registerIR, 32'h0);
    check("clr_mdr", registerMDR, 32'h0);
    check("clr_mar", MAR_address, 32'h0);
    check("clr_outport", outport_data, 32'h0);
    check("clr_conff", {31'b0, con_ff_bit}, 32'h0);
    Zlo_out = 1'b1; #1;
    check("clr_zlo", BusMuxOut, 32'h0);
    Zlo_out = 1'b0; Inport_out = 1'b1; #1;
    check("clr_inport", BusMuxOut, 32'h0);
    idle();
    Mem_enable512x32 = 1'b1; Mem_Read = 1'b1; #1;
    check("mem_kept_over_clear", Mem_to_datapath, 32'h2891_8000);
    idle();
    clear = 1'b1;
    step();
    opcode = 5'd3; Zin = 1'b1; step(); idle();
    Zlo_out = 1'b1; #1;
    check("clr_y_via_add", BusMuxOut, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
